// File: rtl/dsp_add_arbiter.sv
// Round-robin front end that shares one pipelined adder between NREQ clients.
// Results come back in issue order through a credit-guarded FIFO.
module dsp_add_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_a,
   input  logic [NREQ*WIDTH-1:0]    req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]         rsp_y,
   output logic                     busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);

   logic [IDW-1:0]   rr_q, rr_d, gid;
   logic             hit, pop, accept, wr;
   logic [CW-1:0]    used_q, used_d, cnt_q, cnt_d;
   logic [PW-1:0]    wp_q, rp_q;
   logic [WIDTH-1:0] sum;

   logic             pv_q  [0:LATENCY];
   logic [IDW-1:0]   pid_q [0:LATENCY];
   logic [WIDTH-1:0] py_q  [0:LATENCY];
   logic [IDW-1:0]   fid_q [0:DEPTH-1];
   logic [WIDTH-1:0] fy_q  [0:DEPTH-1];

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rsp_valid = (cnt_q != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign wr        = pv_q[LATENCY];
   assign rsp_id    = rsp_valid ? fid_q[rp_q] : '0;
   assign rsp_y     = rsp_valid ? fy_q[rp_q] : '0;
   assign busy      = (used_q != '0);

   always_comb begin
      hit = 1'b0;
      gid = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!hit && req_valid[(int'(rr_q) + k) % NREQ]) begin
            hit = 1'b1;
            gid = IDW'((int'(rr_q) + k) % NREQ);
         end
      end
   end

   // A pop in the same cycle frees the slot the new op will need.
   assign accept    = reset & hit & ((used_q < CW'(DEPTH)) | pop);
   assign req_ready = accept ? (NREQ'(1) << gid) : '0;
   assign sum       = req_a[gid*WIDTH +: WIDTH] + req_b[gid*WIDTH +: WIDTH];

   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
      used_d = used_q + CW'(accept) - CW'(pop);
      cnt_d  = cnt_q + CW'(wr) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_q   <= '0;
         used_q <= '0;
         cnt_q  <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
         for (int k = 0; k <= LATENCY; k++) pv_q[k] <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         used_q  <= used_d;
         cnt_q   <= cnt_d;
         pv_q[0] <= accept;
         for (int k = 1; k <= LATENCY; k++) pv_q[k] <= pv_q[k-1];
         if (wr)  wp_q <= inc(wp_q);
         if (pop) rp_q <= inc(rp_q);
      end
   end

   always_ff @(posedge clock) begin
      pid_q[0] <= gid;
      py_q[0]  <= sum;
      for (int k = 1; k <= LATENCY; k++) begin
         pid_q[k] <= pid_q[k-1];
         py_q[k]  <= py_q[k-1];
      end
      if (wr) begin
         fid_q[wp_q] <= pid_q[LATENCY];
         fy_q[wp_q]  <= py_q[LATENCY];
      end
   end

endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Randomized bench for dsp_add_arbiter against a queue-based issue-order model.
// The model tracks each accepted op with its accept edge and derives visibility.
module tb_dsp_add_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 32;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;
   localparam int IDW     = 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_y;
   logic                  busy;

   always #5 clock = ~clock;

   dsp_add_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
   );

   typedef struct {
      int               id;
      logic [WIDTH-1:0] y;
      int               t;
   } op_t;

   op_t q[$];
   int  rr = 0;
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   bit  armed = 0;
   bit  post_rst = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [NREQ*WIDTH-1:0] rnd_vec();
      logic [NREQ*WIDTH-1:0] v;
      for (int i = 0; i < NREQ; i++) v[i*WIDTH +: WIDTH] = $urandom;
      return v;
   endfunction

   function automatic logic [NREQ*WIDTH-1:0] fill(input logic [WIDTH-1:0] x);
      logic [NREQ*WIDTH-1:0] v;
      for (int i = 0; i < NREQ; i++) v[i*WIDTH +: WIDTH] = x;
      return v;
   endfunction

   task automatic step(input logic [NREQ-1:0] rv, input logic rdy,
                       input logic rst_n, input logic [NREQ*WIDTH-1:0] a,
                       input logic [NREQ*WIDTH-1:0] b);
      logic             ev, pop;
      logic [NREQ-1:0]  eg;
      logic [WIDTH-1:0] s;
      int               g, used;
      op_t              o;
      @(negedge clock);
      req_valid = rv;
      rsp_ready = rdy;
      reset     = rst_n;
      req_a     = a;
      req_b     = b;
      #1;
      used = q.size();
      ev   = 1'b0;
      if (used != 0) ev = (cyc >= q[0].t + LATENCY + 1);
      if (armed) begin
         chk("rsp_valid", 64'(rsp_valid), 64'(ev));
         chk("busy", 64'(busy), 64'(used != 0));
         if (ev) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_y", 64'(rsp_y), 64'(q[0].y));
         end
         if (post_rst) begin
            chk("rst_id", 64'(rsp_id), 64'd0);
            chk("rst_y", 64'(rsp_y), 64'd0);
         end
      end
      pop = ev && rdy;
      g   = -1;
      if (rst_n && (used < DEPTH || pop)) begin
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && rv[(rr + k) % NREQ]) g = (rr + k) % NREQ;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(eg));
      if (!rst_n) begin
         q.delete();
         rr       = 0;
         post_rst = 1;
      end else begin
         post_rst = 0;
         if (pop) void'(q.pop_front());
         if (g >= 0) begin
            s    = a[g*WIDTH +: WIDTH] + b[g*WIDTH +: WIDTH];
            o.id = g;
            o.y  = s;
            o.t  = cyc + 1;
            q.push_back(o);
            rr = (g + 1) % NREQ;
         end
      end
      @(posedge clock);
      cyc++;
      if (!rst_n) armed = 1;
   endtask

   initial begin
      logic [NREQ*WIDTH-1:0] a, b;
      logic [NREQ-1:0]       rv;
      req_valid = '0;
      rsp_ready = 1'b0;
      reset     = 1'b0;
      req_a     = '0;
      req_b     = '0;

      repeat (2) step(4'hF, 1'b1, 1'b0, rnd_vec(), rnd_vec());

      a = '0;
      b = '0;
      a[2*WIDTH +: WIDTH] = 32'd1;
      b[2*WIDTH +: WIDTH] = 32'hffff0001;
      step(4'b0100, 1'b1, 1'b1, a, b);
      repeat (6) step(4'b0000, 1'b1, 1'b1, a, b);

      for (int i = 0; i < NREQ; i++) a[i*WIDTH +: WIDTH] = i;
      repeat (8) step(4'hF, 1'b1, 1'b1, a, a);
      repeat (8) step(4'h0, 1'b1, 1'b1, a, a);

      repeat (8)  step(4'b0010, 1'b0, 1'b1, rnd_vec(), rnd_vec());
      repeat (10) step(4'b0010, 1'b1, 1'b1, rnd_vec(), rnd_vec());
      repeat (8)  step(4'b0000, 1'b1, 1'b1, rnd_vec(), rnd_vec());

      repeat (4) step(4'hF, 1'b1, 1'b1, fill('1), fill(32'd1));
      repeat (6) step(4'h0, 1'b1, 1'b1, fill('1), fill(32'd1));

      repeat (3) step(4'hF, 1'b0, 1'b1, rnd_vec(), rnd_vec());
      step(4'h0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
      repeat (10) step(4'h0, 1'b1, 1'b1, rnd_vec(), rnd_vec());

      for (int n = 0; n < 3000; n++) begin
         rv = NREQ'($urandom);
         a  = rnd_vec();
         b  = rnd_vec();
         if ($urandom_range(0, 7) == 0) a = fill('1);
         step(rv, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0),
              a, b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
